// File: rtl/aes_pkg.sv
// Shared AES constants and types: round count, key-expansion Rcon table,
// state/word typedefs and the RotWord helper.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    // Round counter value at which the last round key is applied
    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

    // Rcon[1..10] stored at indices 0..9
    localparam logic [0:NUM_ROUNDS-1][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Cyclic left rotate of a word by one byte
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, 8-bit purely combinational lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup
    always_comb out_byte = SBOX[in_byte];

endmodule

// File: rtl/round_key_add.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// Registers state_in ^ round_key on each accepted beat and steps the key
// schedule one round per beat; after round 10 the schedule wraps to the
// master key. Optional macro ROUND_KEY_ADD_ZEROIZE_EN wipes the key after
// round 10 so every block needs a fresh key_load.
module round_key_add
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_idx,
    output logic         final_round
);

    aes_state_t master_key_q, master_key_d;
    aes_state_t round_key_q,  round_key_d;
    aes_state_t state_out_q,  state_out_d;
    logic [3:0] round_q,      round_d;
    logic       key_valid_q,  key_valid_d;
    logic       out_valid_q,  out_valid_d;

    aes_word_t  rot_w;
    aes_word_t  sub_w;
    aes_word_t  temp_w;
    logic [7:0] rcon_byte;
    aes_state_t next_key;
    logic       accept;

    // SubWord: four parallel S-boxes on the rotated last word
    assign rot_w = rot_word(round_key_q[31:0]);
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*i +: 8]),
            .out_byte (sub_w[8*i +: 8])
        );
    end

    // One key-expansion step: g-function then XOR chain across the four words
    always_comb begin
        rcon_byte = (round_q < ROUND_LAST) ? RCON[round_q] : '0;
        temp_w    = sub_w ^ {rcon_byte, 24'h0};
        next_key[127:96] = round_key_q[127:96] ^ temp_w;
        next_key[95:64]  = round_key_q[95:64]  ^ next_key[127:96];
        next_key[63:32]  = round_key_q[63:32]  ^ next_key[95:64];
        next_key[31:0]   = round_key_q[31:0]   ^ next_key[63:32];
    end

    // Input handshake; key_load blocks acceptance in its cycle
    always_comb begin
        in_ready = key_valid_q & ~key_load & (~out_valid_q | out_ready);
        accept   = in_valid & in_ready;
    end

    // Next-state: key load, beat acceptance with key advance, output drain
    always_comb begin
        master_key_d = master_key_q;
        round_key_d  = round_key_q;
        state_out_d  = state_out_q;
        round_d      = round_q;
        key_valid_d  = key_valid_q;
        out_valid_d  = out_valid_q;
        if (key_load) begin
            master_key_d = key_in;
            round_key_d  = key_in;
            round_d      = '0;
            key_valid_d  = 1'b1;
            out_valid_d  = 1'b0;
        end else if (accept) begin
            state_out_d = state_in ^ round_key_q;
            out_valid_d = 1'b1;
            if (round_q == ROUND_LAST) begin
                round_d = '0;
`ifdef ROUND_KEY_ADD_ZEROIZE_EN
                master_key_d = '0;
                round_key_d  = '0;
                key_valid_d  = 1'b0;
`else
                round_key_d  = master_key_q;
`endif
            end else begin
                round_d     = round_q + 4'd1;
                round_key_d = next_key;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master_key_q <= '0;
            round_key_q  <= '0;
            state_out_q  <= '0;
            round_q      <= '0;
            key_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            master_key_q <= master_key_d;
            round_key_q  <= round_key_d;
            state_out_q  <= state_out_d;
            round_q      <= round_d;
            key_valid_q  <= key_valid_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign state_out   = state_out_q;
    assign out_valid   = out_valid_q;
    assign round_idx   = round_q;
    assign final_round = (round_q == ROUND_LAST);

endmodule

// File: tb/tb_round_key_add.sv
// Scoreboard bench for round_key_add: random and directed stimulus against
// a reference model that derives the S-box from GF(2^8) arithmetic and the
// full round-key schedule from the FIPS-197 word recurrence.
module tb_round_key_add;

    logic         clk = 1'b0;
    logic         rst_n, key_load, in_valid, out_ready;
    logic [127:0] key_in, state_in;
    logic         in_ready, out_valid, final_round;
    logic [127:0] state_out;
    logic [3:0]   round_idx;

    round_key_add dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_load    (key_load),
        .key_in      (key_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .state_in    (state_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .state_out   (state_out),
        .round_idx   (round_idx),
        .final_round (final_round)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]   sb [256];
    logic [127:0] rks [11];
    logic [127:0] sbq [$];
    logic         m_kv, m_ov;
    int           m_round;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Multiplicative inverse followed by the affine transform
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Reference model: checks control outputs, then applies this cycle's inputs
    initial begin
        m_kv = 1'b0; m_ov = 1'b0; m_round = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_state_out", state_out, 128'h0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_round_idx", round_idx, 0);
                chk("rst_final_round", final_round, 0);
                m_kv = 1'b0; m_ov = 1'b0; m_round = 0;
                sbq.delete();
            end else begin
                logic exp_ready;
                exp_ready = m_kv && !key_load && (!m_ov || out_ready);
                chk("in_ready", in_ready, exp_ready);
                chk("out_valid", out_valid, m_ov);
                chk("round_idx", round_idx, 128'(m_round));
                chk("final_round", final_round, m_round == 10);
                if (key_load) begin
                    expand(key_in);
                    m_kv = 1'b1; m_ov = 1'b0; m_round = 0;
                    sbq.delete();
                end else if (in_valid && exp_ready) begin
                    sbq.push_back(state_in ^ rks[m_round]);
                    m_ov = 1'b1;
                    if (m_round == 10) begin
                        m_round = 0;
`ifdef ROUND_KEY_ADD_ZEROIZE_EN
                        m_kv = 1'b0;
`endif
                    end else begin
                        m_round++;
                    end
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented output with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !key_load && out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    chk("state_out", state_out, sbq[0]);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        build_sbox();
        rst_n = 1'b0; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key_in = '0; state_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();

        // FIPS-197 example, round 0
        key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_load = 1'b1; step(); key_load = 1'b0;
        in_valid = 1'b1; state_in = 128'h3243f6a8885a308d313198a2e0370734; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fips_round0", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("fips_round0_idx", round_idx, 1);
        step(); out_ready = 1'b1; step();

        // Round-key chain via zero states
        key_load = 1'b1; step(); key_load = 1'b0;
        in_valid = 1'b1; state_in = '0; out_ready = 1'b1;
        for (int b = 0; b <= 10; b++) begin
            step();
            if (b == 0)  chk("chain_beat0", state_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
            if (b == 1)  chk("chain_beat1", state_out, 128'ha0fafe1788542cb123a339392a6c7605);
            if (b == 10) chk("chain_beat10", state_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end
        in_valid = 1'b0;
`ifdef ROUND_KEY_ADD_ZEROIZE_EN
        chk("zeroize_in_ready", in_ready, 0);
`else
        chk("wrap_round_idx", round_idx, 0);
`endif
        step();

        // Backpressure
        key_load = 1'b1; step(); key_load = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) begin state_in = {4{$urandom}}; step(); end
        out_ready = 1'b0;
        repeat (5) begin state_in = {4{$urandom}}; step(); end
        out_ready = 1'b1;
        repeat (4) begin state_in = {4{$urandom}}; step(); end
        in_valid = 1'b0; step(); step();

        // Key reload at round 4 with a competing input beat
        key_load = 1'b1; step(); key_load = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (4) begin state_in = {4{$urandom}}; step(); end
        chk("pre_reload_round", round_idx, 4);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1; step(); key_load = 1'b0;
        chk("reload_out_valid", out_valid, 0);
        chk("reload_round_idx", round_idx, 0);
        state_in = {4{$urandom}}; step();
        in_valid = 1'b0; step();

        // Random traffic with occasional key reloads and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(399) == 0) begin
                key_load = 1'b0; in_valid = 1'b0;
                rst_n = 1'b0; step(); rst_n = 1'b1;
            end else begin
                key_load  = ($urandom_range(47) == 0);
                key_in    = {$urandom, $urandom, $urandom, $urandom};
                in_valid  = ($urandom_range(3) != 0);
                state_in  = {$urandom, $urandom, $urandom, $urandom};
                out_ready = ($urandom_range(3) != 0);
                step();
            end
        end
        key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_key_add.md
ROUND_KEY_ADD -- requirements
Module: round_key_add

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `key_load`, input, 1 bit: single-cycle strobe that captures `key_in`.
REQ-004 SHALL have port `key_in`, input, 128 bits: AES-128 cipher key, byte 0 in [127:120].
REQ-005 SHALL have port `in_valid`, input, 1 bit, and port `in_ready`, output, 1 bit: input handshake for `state_in`.
REQ-006 SHALL have port `state_in`, input, 128 bits: state from the upstream mix-columns stage, byte 0 in [127:120].
REQ-007 SHALL have port `out_valid`, output, 1 bit, and port `out_ready`, input, 1 bit: output handshake.
REQ-008 SHALL have port `state_out`, output, 128 bits: registered `state_in` XOR current round key.
REQ-009 SHALL have port `round_idx`, output, 4 bits: round index of the key to be applied next, range 0..10.
REQ-010 SHALL have port `final_round`, output, 1 bit: high when `round_idx`==10; drives the upstream mix-columns bypass.

Function
REQ-011 SHALL hold the master key, the current round key, a 4-bit round counter and a `key_valid` flag as internal registers.
REQ-012 On `key_load`: master key <= `key_in`, round key <= `key_in`, round <= 0, `key_valid` <= 1, `out_valid` <= 0 (any pending output is discarded).
REQ-013 SHALL drive `in_ready` = `key_valid` & !`key_load` & (!`out_valid` | `out_ready`).
REQ-014 On handshake (`in_valid` & `in_ready`): `state_out` <= `state_in` ^ round key, `out_valid` <= 1; latency is 1 cycle.
REQ-015 In the same handshake cycle, SHALL advance the round key by one FIPS-197 expansion step: RotWord, SubWord (4 S-boxes), Rcon[round+1], XOR chain; round <= round+1.
REQ-016 When a handshake occurs at round 10: round <= 0 and round key <= master key; there SHALL be no expansion.
REQ-017 `out_valid` SHALL clear on `out_ready` when no new handshake occurs in that cycle; a simultaneous drain and accept SHALL keep `out_valid` high with the new data.
REQ-018 `state_out` SHALL hold stable while `out_valid` & !`out_ready`.
REQ-019 `key_load` SHALL take priority over a same-cycle input handshake; the input is not accepted in that cycle.
REQ-020 Throughput SHALL be one state per cycle; no bubble between rounds or between consecutive blocks.

Reset
REQ-021 On `rst_n` low, all registers SHALL clear asynchronously: `state_out`=0, `out_valid`=0, `round_idx`=0, `final_round`=0, `key_valid`=0, and master and round keys =0.
REQ-022 `in_ready` SHALL be 0 during reset and until the first `key_load`.

Configuration
REQ-023 With `ROUND_KEY_ADD_ZEROIZE_EN` defined: after the round-10 handshake, the master key and round key SHALL clear to 0 and `key_valid` SHALL clear to 0, so a new `key_load` is required per block.
REQ-024 Without `ROUND_KEY_ADD_ZEROIZE_EN`: the key SHALL be retained and the block wraps to round 0 per REQ-016.

Structure
REQ-025 Shared package `aes_pkg` SHALL hold `NUM_ROUNDS`=10, the Rcon table (01,02,04,08,10,20,40,80,1b,36) and a 128-bit state typedef.
REQ-026 Sub-module `aes_sbox` (8-bit combinational forward S-box) SHALL be instantiated 4 times for SubWord.

Verification
REQ-027 Key load and round 0: load key 2b7e151628aed2a6abf7158809cf4f3c, send state_in 3243f6a8885a308d313198a2e0370734 -> `state_out` 193de3bea0f4e22b9ac68d2ae9f84808 one cycle later, with `round_idx` 1.
REQ-028 Round-key chain: send state_in 0 for 11 beats -> outputs equal round keys 0..10; beat 1 = a0fafe1788542cb123a339392a6c7605, beat 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; `final_round` high only before beat 10.
REQ-029 Backpressure: hold `out_ready`=0 for 5 cycles -> `in_ready`=0, `state_out` stable, round does not advance; release -> stream resumes with no loss.
REQ-030 Key reload mid-block at round 4 -> `out_valid` drops, `round_idx`=0, next output uses the new key.
REQ-031 Reset mid-stream, and the zeroize build: after round 10 -> `in_ready`=0 until `key_load` (macro on), or wrap to round 0 with the original key (macro off).
